// File: rtl/avalon_cmd_csr.sv
// avalon_cmd_csr: Avalon-MM command FIFO / status / buffer-select / control slave.
// Define AVS_CSR_IRQ_EN to enable the registered interrupt and the writable CTRL[0] irq_en bit.
module avalon_cmd_csr #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STATUS_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                read,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic [DATA_W-1:0]   cmd_data,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    input  logic                core_busy,
    input  logic                core_done,
    input  logic [STATUS_W-1:0] core_status,
    output logic                buf_sel,
    output logic                irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              done, ovf, auto_swap, irq_en;
    logic              wr, rd, full, empty, push_req, push, pop, flush, clr_done, clr_ovf, bufsel_wr, ctrl_wr;
    logic [DATA_W-1:0] status, rd_mux;

    assign wr        = chipselect & write;
    assign rd        = chipselect & read;
    assign full      = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign cmd_valid = !empty;
    assign cmd_data  = mem[rd_ptr];
    assign push_req  = wr && address == 3'd0;
    assign ctrl_wr   = wr && address == 3'd3;
    assign bufsel_wr = wr && address == 3'd2;
    assign flush     = ctrl_wr && writedata[2];
    // A flush discards any coinciding push; a push into a full FIFO is dropped even if a pop frees a slot
    assign push      = push_req && !full && !flush;
    assign pop       = cmd_valid && cmd_ready;
    assign clr_done  = wr && address == 3'd4 && writedata[0];
    assign clr_ovf   = wr && address == 3'd4 && writedata[1];

    // Assemble STATUS and select the read-data source for the addressed register
    always_comb begin
        status        = '0;
        status[0]     = core_busy;
        status[1]     = done;
        status[2]     = ovf;
        status[3]     = full;
        status[4]     = empty;
        status[15:8]  = 8'(count);
        status[31:16] = 16'(core_status);
        rd_mux = address == 3'd1 ? status :
                 address == 3'd2 ? DATA_W'(buf_sel) :
                 address == 3'd3 ? DATA_W'({auto_swap, irq_en}) : '0;
    end

    // FIFO storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata;
    end

    // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Sticky flags (set beats clear), buffer select, CTRL bits and registered read response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done          <= 1'b0;
            ovf           <= 1'b0;
            buf_sel       <= 1'b0;
            auto_swap     <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            done          <= core_done | (done & ~clr_done);
            ovf           <= (push_req && full && !flush) | (ovf & ~clr_ovf);
            buf_sel       <= bufsel_wr ? writedata[0] : (auto_swap && core_done) ? ~buf_sel : buf_sel;
            auto_swap     <= ctrl_wr ? writedata[1] : auto_swap;
            readdata      <= rd ? rd_mux : readdata;
            readdatavalid <= rd;
        end
    end

`ifdef AVS_CSR_IRQ_EN
    // Interrupt enable and registered level interrupt, one cycle behind the flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= ctrl_wr ? writedata[0] : irq_en;
            irq    <= irq_en & (done | ovf);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_cmd_csr.sv
// tb_avalon_cmd_csr: scoreboard bench for avalon_cmd_csr (read and command queues checked against expectations).
module tb_avalon_cmd_csr;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, cmd_data;
    logic        readdatavalid, cmd_valid, buf_sel, irq;
    logic        cmd_ready = 1'b0, core_busy = 1'b0, core_done = 1'b0;
    logic [7:0]  core_status = '0;

    int checks = 0, failures = 0;
    logic [31:0] rq[$];
    logic [31:0] cq[$];

    avalon_cmd_csr #(.DATA_W(32), .FIFO_DEPTH(4), .STATUS_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .read(read), .readdata(readdata),
        .readdatavalid(readdatavalid), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .core_busy(core_busy), .core_done(core_done),
        .core_status(core_status), .buf_sel(buf_sel), .irq(irq)
    );

    always #5 clk = ~clk;

    // Read scoreboard: every readdatavalid pops one expected value
    always @(negedge clk) begin
        if (readdatavalid) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL rdv_unexpected readdata=%h", readdata);
            end else begin
                logic [31:0] e;
                e = rq.pop_front();
                if (readdata !== e) begin
                    failures++;
                    $display("FAIL readdata got=%h exp=%h", readdata, e);
                end
            end
        end
    end

    function automatic logic [31:0] st(input logic busy, input logic dn, input logic ov, input int cnt, input logic [7:0] cs);
        return {8'h0, cs, 8'(cnt), 3'b0, cnt == 0, cnt == 4, ov, dn, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1; address = a; writedata = d;
        step();
        write = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, input logic [31:0] e);
        read = 1'b1; address = a;
        rq.push_back(e);
        step();
        checks++;
        if (readdatavalid !== 1'b1) begin
            failures++;
            $display("FAIL rdv_latency got=%b exp=1", readdatavalid);
        end
        read = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && rq.size() != 0; i++) @(negedge clk);
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL rd_drain pending=%0d exp=0", rq.size());
            rq.delete();
        end
    endtask

    task automatic wr_cmd(input logic [31:0] d);
        if (cq.size() < 4) cq.push_back(d);
        wr_reg(3'd0, d);
    endtask

    task automatic pop_check(input int n);
        cmd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            e = cq.pop_front();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== e) begin
                failures++;
                $display("FAIL pop[%0d] valid=%b data=%h exp=%h", i, cmd_valid, cmd_data, e);
            end
            step();
        end
        cmd_ready = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic done_pulse();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_rdv", 32'(readdatavalid), 0);
        chk("rst_buf_sel", 32'(buf_sel), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_irq", 32'(irq), 0);
        reset_n = 1'b1;
        chipselect = 1'b1;
        step();
        rd_reg(3'd1, st(0, 0, 0, 0, 8'h00));
        core_busy = 1'b1; core_status = 8'hA5;
        rd_reg(3'd1, st(1, 0, 0, 0, 8'hA5));
        core_busy = 1'b0; core_status = 8'h00;
        rd_reg(3'd5, 32'h0);
        drain();
    endtask

    task automatic test_fifo_ovf();
        for (int i = 0; i < 5; i++) wr_cmd(32'hA1 + 32'(i));
        rd_reg(3'd1, st(0, 0, 1, 4, 8'h00));
        drain();
        pop_check(4);
        chk("ovf_empty_after_pops", 32'(cmd_valid), 0);
        wr_reg(3'd4, 32'h2);
        rd_reg(3'd1, st(0, 0, 0, 0, 8'h00));
        drain();
    endtask

    task automatic test_push_pop();
        wr_cmd(32'hB1);
        wr_cmd(32'hB2);
        cmd_ready = 1'b1;
        chk("pp_head", cmd_data, cq.pop_front());
        cq.push_back(32'hB3);
        wr_reg(3'd0, 32'hB3);
        cmd_ready = 1'b0;
        rd_reg(3'd1, st(0, 0, 0, 2, 8'h00));
        drain();
        pop_check(2);
        wr_cmd(32'hC1);
        chk("flush_pre_valid", 32'(cmd_valid), 1);
        wr_reg(3'd3, 32'h4);
        chk("flush_valid", 32'(cmd_valid), 0);
        cq.delete();
        rd_reg(3'd1, st(0, 0, 0, 0, 8'h00));
        rd_reg(3'd3, 32'h0);
        drain();
    endtask

    task automatic test_back_to_back();
        wr_reg(3'd2, 32'h1);
        rd_reg(3'd2, 32'h1);
        rd_reg(3'd1, st(0, 0, 0, 0, 8'h00));
        rd_reg(3'd2, 32'h1);
        rd_reg(3'd7, 32'h0);
        drain();
        chipselect = 1'b0;
        wr_reg(3'd2, 32'h0);
        chipselect = 1'b1;
        chk("cs_low_ignored", 32'(buf_sel), 1);
        wr_reg(3'd2, 32'h0);
        chk("bufsel_wr0", 32'(buf_sel), 0);
    endtask

    task automatic test_auto_swap();
        wr_reg(3'd3, 32'h2);
        rd_reg(3'd3, 32'h2);
        drain();
        for (int i = 0; i < 3; i++) begin
            done_pulse();
            chk("swap", 32'(buf_sel), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        core_done = 1'b1;
        wr_reg(3'd2, 32'h0);
        core_done = 1'b0;
        chk("swap_wr_wins", 32'(buf_sel), 0);
        wr_reg(3'd3, 32'h0);
        wr_reg(3'd4, 32'h3);
    endtask

    task automatic test_done_clr();
        core_done = 1'b1;
        wr_reg(3'd4, 32'h1);
        core_done = 1'b0;
        rd_reg(3'd1, st(0, 1, 0, 0, 8'h00));
        drain();
        wr_reg(3'd4, 32'h1);
        rd_reg(3'd1, st(0, 0, 0, 0, 8'h00));
        drain();
    endtask

    task automatic test_irq();
`ifdef AVS_CSR_IRQ_EN
        wr_reg(3'd3, 32'h1);
        rd_reg(3'd3, 32'h1);
        drain();
        done_pulse();
        chk("irq_lag", 32'(irq), 0);
        step();
        chk("irq_rise", 32'(irq), 1);
        wr_reg(3'd4, 32'h1);
        chk("irq_clr_lag", 32'(irq), 1);
        step();
        chk("irq_fall", 32'(irq), 0);
        done_pulse();
        step();
        chk("irq_rise2", 32'(irq), 1);
        wr_reg(3'd3, 32'h0);
        chk("irq_dis_lag", 32'(irq), 1);
        step();
        chk("irq_dis_fall", 32'(irq), 0);
`else
        wr_reg(3'd3, 32'h1);
        rd_reg(3'd3, 32'h0);
        drain();
        done_pulse();
        for (int i = 0; i < 3; i++) begin
            chk("irq_tied", 32'(irq), 0);
            step();
        end
        wr_reg(3'd3, 32'h0);
`endif
        wr_reg(3'd4, 32'h3);
    endtask

    task automatic test_reset_mid();
        wr_cmd(32'hD1);
        chk("mid_valid", 32'(cmd_valid), 1);
        read = 1'b1; address = 3'd1;
        step();
        read = 1'b0;
        chk("mid_rdv_pending", 32'(readdatavalid), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rdv_drop", 32'(readdatavalid), 0);
        chk("mid_fifo_clear", 32'(cmd_valid), 0);
        chk("mid_readdata", readdata, 0);
        cq.delete();
        step();
        reset_n = 1'b1;
        step();
        chk("mid_after_valid", 32'(cmd_valid), 0);
    endtask

    initial begin
        test_reset();
        test_fifo_ovf();
        test_push_pop();
        test_back_to_back();
        test_auto_swap();
        test_done_clr();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/avalon_cmd_csr.md
# avalon_cmd_csr

Parametrised Avalon-MM slave that sits between the HPS bridge and the arithmetic core. It holds a command FIFO, status, buffer-select and control registers. It dispatches queued commands to the core with a valid/ready handshake, latches completion and overflow events as sticky flags, and optionally raises an interrupt. It supersedes the single-register command/status slave: commands are queued, reads are registered, and the buffer select can ping-pong automatically on completion.

## Interface
- DATA_W, 32, Avalon data and command width.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, range 2..64.
- STATUS_W, 8, width of core status input; must be ≤ 16.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write  in  1  write strobe.
- writedata  in  DATA_W  write data.
- read  in  1  read strobe.
- readdata  out  DATA_W  registered read data.
- readdatavalid  out  1  one-cycle pulse with readdata.
- cmd_data  out  DATA_W  FIFO head command.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  core accepts head.
- core_busy  in  1  live core busy level.
- core_done  in  1  one-cycle completion pulse.
- core_status  in  STATUS_W  live core status.
- buf_sel  out  1  active buffer select.
- irq  out  1  level interrupt.

## Operation
- Register map (write = chipselect&write, read = chipselect&read):
  - 0 CMD (W): push writedata. If count==FIFO_DEPTH, the push is dropped, OVF is set, and a same-cycle pop does not rescue it.
  - 1 STATUS (R): [0] core_busy, [1] DONE, [2] OVF, [3] full, [4] empty, [15:8] count zero-extended, [31:16] core_status zero-extended.
  - 2 BUFSEL (R/W): bit0 = buf_sel.
  - 3 CTRL (R/W): [0] irq_en, [1] auto_swap, [2] flush (write-1 pulse, reads 0).
  - 4 CLR (W): write-1-to-clear; [0] DONE, [1] OVF.
  - Other addresses: writes ignored, reads return 0.
- FIFO:
  - Pop when cmd_valid && cmd_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_data is the head entry; it is undefined (don't-care) when empty.
  - Flush zeroes the count and pointers. If a push coincides with a flush, the flush wins and the push is discarded without setting OVF.
- DONE is set on core_done.
  - If core_done and CLR[0] occur in the same cycle, set wins.
  - Same rule for OVF against CLR[1].
- auto_swap=1: each core_done toggles buf_sel. A BUFSEL write in the same cycle wins over the toggle.
- Reset values:
  - Outputs: readdata=0, readdatavalid=0, buf_sel=0, cmd_valid=0, irq=0.
  - Internal: FIFO empty, DONE=OVF=0, CTRL=0.

## Timing
- Read accepted at edge t → readdata and readdatavalid at t+1. Fixed latency 1, no waitrequest.
- Back-to-back reads are supported every cycle.
- STATUS returns the value sampled at edge t.
- Write at edge t → register, FIFO and count visible from t+1.
- Push into an empty FIFO at t → cmd_valid=1 from t+1.
- Pop of the last entry at t → cmd_valid=0 from t+1.
- Reset asserted mid-transfer clears the FIFO immediately. Any pending readdatavalid is dropped.

## Configuration
- AVS_CSR_IRQ_EN defined:
  - irq = irq_en & (DONE | OVF), registered.
  - irq rises one cycle after the flag sets.
  - irq falls one cycle after CLR or irq_en=0.
- Not defined:
  - irq tied to 0.
  - CTRL[0] is not writable and reads 0.
  - All other behaviour unchanged.

## Test plan
- Reset, read STATUS → readdatavalid at +1; readdata bits show empty=1, count=0, DONE=OVF=0; buf_sel=0.
- With cmd_ready=0, write CMD 0xA1..0xA5 (DEPTH=4) → count=4, full=1, OVF=1; then cmd_ready=1 pops 0xA1..0xA4 in order, one per cycle.
- Push and pop in the same cycle at count=2 → count stays 2, order preserved. Flush write → cmd_valid=0 next cycle.
- auto_swap=1, three core_done pulses → buf_sel 1,0,1. BUFSEL write of 0 coinciding with a core_done → buf_sel=0.
- core_done in the same cycle as CLR[0] → DONE stays 1. A later CLR alone → DONE=0.
- With AVS_CSR_IRQ_EN and irq_en=1, core_done → irq=1 one cycle after DONE sets; CLR → irq=0 one cycle after. Without the macro → irq stays 0 throughout.
